// File: rtl/boot_sequencer.sv
// Boot sequencer for the pulpino SoC: programs the boot-address register, waits for
// the image load, enables instruction fetch and reads back the software return code.
module boot_sequencer #(
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
  parameter logic [31:0] BOOT_REG_ADDR   = 32'h1A10_7008,
  parameter logic [31:0] STATUS_ADDR     = 32'h1A10_7010,
  parameter int unsigned RST_WAIT_CYCLES = 16,
  parameter int unsigned FETCH_DELAY     = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_o,
  input  logic        gnt_i,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  input  logic        load_done_i,
  input  logic        load_bypass_i,
  input  logic        eoc_i,
  output logic        fetch_enable_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [31:0] ret_code_o,
  output logic [3:0]  state_o
);

  // Bus handshake: a request is held with constant we/addr/wdata until gnt is
  // sampled high; the response (rvalid) is only accepted from the cycle after grant.
  typedef enum logic [3:0] {
    ST_WAIT      = 4'd0,
    ST_CFG_REQ   = 4'd1,
    ST_CFG_RSP   = 4'd2,
    ST_LOAD_WAIT = 4'd3,
    ST_FETCH_DLY = 4'd4,
    ST_RUN       = 4'd5,
    ST_RC_REQ    = 4'd6,
    ST_RC_RSP    = 4'd7,
    ST_DONE      = 4'd8
  } state_t;

  localparam logic [15:0] RST_WAIT_INIT = 16'(RST_WAIT_CYCLES);
  localparam logic [15:0] FETCH_INIT    = 16'(FETCH_DELAY);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic        load_seen;
  logic        eoc_s1, eoc_s2;

  logic        req_n, we_n, fetch_n, done_n, pass_n;
  logic [31:0] addr_n, wdata_n, ret_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = 1'b0;
    we_n    = 1'b0;
    addr_n  = '0;
    wdata_n = '0;
    fetch_n = fetch_enable_o;
    done_n  = done_o;
    pass_n  = pass_o;
    ret_n   = ret_code_o;

    case (state)
      ST_WAIT: begin
        if (cnt == 16'd0) state_n = ST_CFG_REQ;
        else              cnt_n   = cnt - 16'd1;
      end
      ST_CFG_REQ:   if (gnt_i) state_n = ST_CFG_RSP;
      ST_CFG_RSP:   if (rvalid_i) state_n = ST_LOAD_WAIT;
      ST_LOAD_WAIT: begin
        if (load_bypass_i || load_seen) begin
          cnt_n   = FETCH_INIT;
          state_n = ST_FETCH_DLY;
        end
      end
      ST_FETCH_DLY: begin
        if (cnt == 16'd0) state_n = ST_RUN;
        else              cnt_n   = cnt - 16'd1;
      end
      ST_RUN:       if (eoc_s2) state_n = ST_RC_REQ;
      ST_RC_REQ:    if (gnt_i) state_n = ST_RC_RSP;
      ST_RC_RSP: begin
        if (rvalid_i) begin
          ret_n   = rdata_i;
          pass_n  = (rdata_i == 32'd0);
          done_n  = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE:      state_n = ST_DONE;
      default:      state_n = ST_WAIT;
    endcase

    // Outputs are decoded from the next state so every bus output is a flop.
    if (state_n == ST_CFG_REQ) begin
      req_n   = 1'b1;
      we_n    = 1'b1;
      addr_n  = BOOT_REG_ADDR;
      wdata_n = BOOT_ADDR;
    end
    if (state_n == ST_RC_REQ) begin
      req_n  = 1'b1;
      addr_n = STATUS_ADDR;
    end
    if (state_n == ST_RUN) fetch_n = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_WAIT;
      cnt            <= RST_WAIT_INIT;
      load_seen      <= 1'b0;
      eoc_s1         <= 1'b0;
      eoc_s2         <= 1'b0;
      req_o          <= 1'b0;
      we_o           <= 1'b0;
      addr_o         <= '0;
      wdata_o        <= '0;
      fetch_enable_o <= 1'b0;
      done_o         <= 1'b0;
      pass_o         <= 1'b0;
      ret_code_o     <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      load_seen      <= load_seen | load_done_i;
      eoc_s1         <= eoc_i;
      eoc_s2         <= eoc_s1;
      req_o          <= req_n;
      we_o           <= we_n;
      addr_o         <= addr_n;
      wdata_o        <= wdata_n;
      fetch_enable_o <= fetch_n;
      done_o         <= done_n;
      pass_o         <= pass_n;
      ret_code_o     <= ret_n;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed-plus-random bench for boot_sequencer: expected timing is derived from
// the sequencing rules as edge counts, bus transfers are checked against a queue.
module tb_boot_sequencer;

  localparam int          RW        = 4;
  localparam int          FD        = 5;
  localparam logic [31:0] BOOT_A    = 32'h0000_0000;
  localparam logic [31:0] BOOT_REG  = 32'h1A10_7008;
  localparam logic [31:0] STATUS_A  = 32'h1A10_7010;

  localparam logic [3:0] S_WAIT = 4'd0, S_CFG_REQ = 4'd1, S_CFG_RSP = 4'd2,
                         S_LOAD = 4'd3, S_FDLY = 4'd4, S_RUN = 4'd5,
                         S_RC_REQ = 4'd6, S_RC_RSP = 4'd7, S_DONE = 4'd8;

  logic        clk, rst_n;
  logic        req_o, gnt_i, we_o, rvalid_i;
  logic [31:0] addr_o, wdata_o, rdata_i, ret_code_o;
  logic        load_done_i, load_bypass_i, eoc_i;
  logic        fetch_enable_o, done_o, pass_o;
  logic [3:0]  state_o;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [64:0] exp_q[$];

  boot_sequencer #(
    .BOOT_ADDR(BOOT_A), .BOOT_REG_ADDR(BOOT_REG), .STATUS_ADDR(STATUS_A),
    .RST_WAIT_CYCLES(RW), .FETCH_DELAY(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .load_done_i(load_done_i), .load_bypass_i(load_bypass_i), .eoc_i(eoc_i),
    .fetch_enable_o(fetch_enable_o), .done_o(done_o), .pass_o(pass_o),
    .ret_code_o(ret_code_o), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; transfers are counted from the values the coming edge sees.
  task automatic tick();
    if (req_o && gnt_i) begin
      if (we_o) wr_cnt++;
      else      rd_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic grant(input string tag, input bit rv_with_gnt);
    logic [64:0] item;
    item = exp_q.pop_front();
    check({tag, "_xfer"}, {we_o, addr_o, wdata_o}, item);
    gnt_i    = 1'b1;
    rvalid_i = rv_with_gnt;
    tick();
    gnt_i    = 1'b0;
    rvalid_i = 1'b0;
  endtask

  task automatic run_boot(input bit bypass, input bit early_load, input int gnt_wait,
                          input bit rv_with_gnt, input int rsp_wait,
                          input logic [31:0] rc, input bit abort_in_rc);
    logic [64:0] held;
    bit          stable;
    int          eoc_wait;

    exp_q.delete();
    exp_q.push_back({1'b1, BOOT_REG, BOOT_A});
    exp_q.push_back({1'b0, STATUS_A, 32'd0});

    @(negedge clk);
    rst_n = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
    eoc_i = 1'b0; load_done_i = 1'b0; load_bypass_i = bypass;
    #1;
    check("rst_ctrl", {req_o, we_o, fetch_enable_o, done_o, pass_o, state_o}, {5'b0, S_WAIT});
    check("rst_data", {addr_o, wdata_o}, 65'd0);
    check("rst_ret", ret_code_o, 65'd0);
    tick(); tick();
    rst_n = 1'b1;
    wr_cnt = 0; rd_cnt = 0;

    // idle window after reset, optional early load pulse
    for (int e = 1; e <= RW; e++) begin
      load_done_i = (e == 1) && early_load;
      tick();
      load_done_i = 1'b0;
      check("wait_idle", {req_o, state_o}, {1'b0, S_WAIT});
    end
    tick();
    check("cfg_req", {req_o, we_o, addr_o, wdata_o, state_o}, {1'b1, 1'b1, BOOT_REG, BOOT_A, S_CFG_REQ});

    held = {we_o, addr_o, wdata_o}; stable = 1'b1;
    for (int i = 0; i < gnt_wait; i++) begin
      tick();
      if (!req_o || {we_o, addr_o, wdata_o} !== held) stable = 1'b0;
    end
    check("cfg_stall_stable", stable, 1'b1);
    grant("cfg", rv_with_gnt);
    check("cfg_rsp", {req_o, state_o}, {1'b0, S_CFG_RSP});
    for (int i = 0; i < rsp_wait; i++) begin
      tick();
      check("cfg_rsp_hold", state_o, S_CFG_RSP);
    end
    rvalid_i = 1'b1;
    tick();
    rvalid_i = 1'b0;
    check("load_wait", state_o, S_LOAD);
    check("one_write", wr_cnt, 65'd1);

    if (!bypass && !early_load) begin
      for (int i = 0; i < 30; i++) tick();
      check("load_stall", {fetch_enable_o, state_o}, {1'b0, S_LOAD});
      return;
    end

    tick();
    check("fdly_entry", {fetch_enable_o, state_o}, {1'b0, S_FDLY});
    // spurious eoc pulse, long gone through the synchronizer before RUN
    eoc_i = 1'b1;
    tick();
    eoc_i = 1'b0;
    for (int i = 2; i <= FD; i++) tick();
    check("fdly_hold", {fetch_enable_o, state_o}, {1'b0, S_FDLY});
    tick();
    check("fetch_rise", {fetch_enable_o, state_o}, {1'b1, S_RUN});

    rvalid_i = 1'b1; rdata_i = $urandom;
    tick();
    rvalid_i = 1'b0;
    check("run_spurious", {ret_code_o, state_o}, {32'd0, S_RUN});
    eoc_wait = $urandom_range(0, 5);
    for (int i = 0; i < eoc_wait; i++) tick();
    check("run_hold", {req_o, fetch_enable_o, state_o}, {2'b01, S_RUN});

    eoc_i = 1'b1;
    tick();
    check("eoc_sync1", req_o, 1'b0);
    tick();
    check("eoc_sync2", req_o, 1'b0);
    tick();
    check("rc_req", {req_o, we_o, addr_o, wdata_o, state_o}, {2'b10, STATUS_A, 32'd0, S_RC_REQ});

    if (abort_in_rc) begin
      #2 rst_n = 1'b0;
      #1;
      check("abort_req", {req_o, fetch_enable_o, done_o, state_o}, {3'b000, S_WAIT});
      eoc_i = 1'b0;
      return;
    end

    held = {we_o, addr_o, wdata_o}; stable = 1'b1;
    for (int i = 0; i < gnt_wait; i++) begin
      tick();
      if (!req_o || {we_o, addr_o, wdata_o} !== held) stable = 1'b0;
    end
    check("rc_stall_stable", stable, 1'b1);
    grant("rc", rv_with_gnt);
    check("rc_rsp", {req_o, done_o, state_o}, {2'b00, S_RC_RSP});
    for (int i = 0; i < rsp_wait; i++) tick();
    rvalid_i = 1'b1; rdata_i = rc;
    tick();
    rvalid_i = 1'b0;
    check("done", {done_o, pass_o, fetch_enable_o, req_o, state_o},
          {1'b1, (rc == 32'd0), 2'b10, S_DONE});
    check("ret_code", ret_code_o, rc);

    rvalid_i = 1'b1; rdata_i = ~rc;
    tick();
    rvalid_i = 1'b0;
    check("done_terminal", {ret_code_o, state_o}, {rc, S_DONE});
    check("xfer_counts", {wr_cnt[15:0], rd_cnt[15:0]}, {16'd1, 16'd1});
    eoc_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
    eoc_i = 1'b0; load_done_i = 1'b0; load_bypass_i = 1'b0;

    run_boot(1'b1, 1'b0, 0, 1'b0, 0, 32'd0, 1'b0);          // preload, zero wait states
    run_boot(1'b0, 1'b1, 10, 1'b0, 0, 32'd3, 1'b0);         // SPI early pulse, grant stall
    run_boot(1'b1, 1'b1, 2, 1'b1, 1, 32'd0, 1'b0);          // both strap and pulse
    run_boot(1'b1, 1'b0, 1, 1'b0, 0, 32'd0, 1'b1);          // reset during return-code read
    run_boot(1'b0, 1'b0, 0, 1'b0, 0, 32'd0, 1'b0);          // no load: stays in LOAD_WAIT
    for (int n = 0; n < 6; n++) begin
      bit          byp;
      logic [31:0] rc;
      byp = 1'($urandom_range(0, 1));
      rc  = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      run_boot(byp, !byp || 1'($urandom_range(0, 1)), $urandom_range(0, 6),
               1'($urandom_range(0, 1)), $urandom_range(0, 4), rc, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
